// File: rtl/storemerge_rv32i.sv
// Store path for a word-only data memory: SW is written directly, while SB and SH
// read the word, merge in the new lane and write it back. Port "store_type" is the funct3 input.
module storemerge_rv32i #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            store_type,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           merged;
  logic                  req_ok;

  // Reject misaligned halfwords/words and any funct3 that is not a store.
  always_comb begin
    req_ok = 1'b0;
    case (store_type)
      F3_SB:   req_ok = 1'b1;
      F3_SH:   req_ok = ~addr[0];
      F3_SW:   req_ok = (addr[1:0] == 2'b00);
      default: req_ok = 1'b0;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (type_q == F3_SB) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!req_ok)                 state_d = S_ERR;
          else if (store_type == F3_SW) state_d = S_WRITE;
          else                         state_d = S_READ;
        end
      end
      S_READ:  if (mem_ready) state_d = S_WRITE;
      S_WRITE: if (mem_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        type_q  <= store_type;
        addr_q  <= addr;
        wdata_q <= wdata;
      end else if (state_q == S_READ && mem_ready) begin
        wdata_q <= merged;
      end
    end
  end

  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == S_READ);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_storemerge_rv32i.sv
// Directed bench for storemerge_rv32i: a one-word memory model with programmable
// read/write stall counts, plus monitors for access counts and handshake stability.
module tb_storemerge_rv32i;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  stype = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ready, busy, done, err;

  int errors = 0;
  int checks = 0;

  // Memory model and monitors; preload resets counters and stall budgets.
  logic        load_en = 1'b0;
  logic [31:0] load_val = '0;
  int          load_rd = 0, load_wr = 0;
  logic [31:0] mem_word;
  int          rd_left = 0, wr_left = 0;
  int          re_cnt = 0, we_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic        prev_stall = 1'b0, unstable = 1'b0, both_hi = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_word;
  assign mem_ready = !((mem_re && rd_left != 0) || (mem_we && wr_left != 0));

  always @(posedge clk) begin
    if (load_en) begin
      mem_word   <= load_val;
      rd_left    <= load_rd;
      wr_left    <= load_wr;
      re_cnt     <= 0;
      we_cnt     <= 0;
      unstable   <= 1'b0;
      both_hi    <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      if (mem_re) re_cnt <= re_cnt + 1;
      if (mem_we) we_cnt <= we_cnt + 1;
      if (mem_re && rd_left != 0) rd_left <= rd_left - 1;
      if (mem_we && wr_left != 0) wr_left <= wr_left - 1;
      if (mem_we && mem_ready) begin
        mem_word   <= mem_wdata;
        last_addr  <= mem_addr;
        last_wdata <= mem_wdata;
      end
      if (mem_re && mem_we) both_hi <= 1'b1;
      if (prev_stall && (mem_addr != prev_addr || (mem_we && mem_wdata != prev_wdata)))
        unstable <= 1'b1;
      prev_stall <= (mem_re || mem_we) && !mem_ready;
      prev_addr  <= mem_addr;
      prev_wdata <= mem_wdata;
    end
  end

  storemerge_rv32i #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .store_type(stype), .addr(addr),
    .wdata(wdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] v, input int rs, input int ws);
    @(negedge clk);
    load_en = 1'b1; load_val = v; load_rd = rs; load_wr = ws;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issue one store; returns cycles from the accepting edge to done (sampled in the done cycle).
  // With noise set, start stays high with a conflicting SW while the block is busy.
  task automatic run(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                     input bit noise, output int lat);
    @(negedge clk);
    start = 1'b1; stype = t; addr = a; wdata = d;
    @(posedge clk); #1;
    if (noise) begin
      stype = 3'b010; addr = 32'h0000_0200; wdata = 32'h0;
    end else begin
      start = 1'b0;
    end
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      $error("FAIL timeout: no done within %0d cycles", lat);
    end
  endtask

  logic [31:0] sb_exp [4];
  logic [31:0] bad_addr [3];
  logic [2:0]  bad_type [3];
  int lat;

  initial begin
    sb_exp[0] = 32'h1122_33AA; sb_exp[1] = 32'h1122_AA44;
    sb_exp[2] = 32'h11AA_3344; sb_exp[3] = 32'hAA22_3344;
    bad_type[0] = 3'b001; bad_addr[0] = 32'h0000_0101;
    bad_type[1] = 3'b010; bad_addr[1] = 32'h0000_0102;
    bad_type[2] = 3'b011; bad_addr[2] = 32'h0000_0100;

    #3;
    chk("rst_re", {31'b0, mem_re}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    preload(32'h1122_3344, 0, 0);
    run(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, lat);
    chk("sw_lat", lat, 32'd2);
    chk("sw_err", {31'b0, err}, 32'd0);
    chk("sw_re_cnt", re_cnt, 32'd0);
    chk("sw_we_cnt", we_cnt, 32'd1);
    chk("sw_addr", last_addr, 32'h0000_0100);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_word", mem_word, 32'hDEAD_BEEF);

    for (int k = 0; k < 4; k++) begin
      preload(32'h1122_3344, 0, 0);
      run(3'b000, 32'h0000_0100 + k, 32'hFFFF_FFAA, 1'b0, lat);
      chk($sformatf("sb%0d_lat", k), lat, 32'd3);
      chk($sformatf("sb%0d_err", k), {31'b0, err}, 32'd0);
      chk($sformatf("sb%0d_addr", k), last_addr, 32'h0000_0100);
      chk($sformatf("sb%0d_word", k), mem_word, sb_exp[k]);
    end

    preload(32'h1122_3344, 0, 0);
    run(3'b001, 32'h0000_0100, 32'h0000_BEEF, 1'b0, lat);
    chk("sh0_lat", lat, 32'd3);
    chk("sh0_word", mem_word, 32'h1122_BEEF);
    preload(32'h1122_3344, 0, 0);
    run(3'b001, 32'h0000_0102, 32'h0000_BEEF, 1'b0, lat);
    chk("sh1_lat", lat, 32'd3);
    chk("sh1_addr", last_addr, 32'h0000_0100);
    chk("sh1_word", mem_word, 32'hBEEF_3344);

    for (int k = 0; k < 3; k++) begin
      preload(32'h1122_3344, 0, 0);
      run(bad_type[k], bad_addr[k], 32'hCAFE_CAFE, 1'b0, lat);
      chk($sformatf("bad%0d_lat", k), lat, 32'd1);
      chk($sformatf("bad%0d_err", k), {31'b0, err}, 32'd1);
      chk($sformatf("bad%0d_acc", k), re_cnt + we_cnt, 32'd0);
      chk($sformatf("bad%0d_word", k), mem_word, 32'h1122_3344);
    end

    preload(32'h1122_3344, 3, 2);
    run(3'b000, 32'h0000_0101, 32'hFFFF_FFAA, 1'b1, lat);
    chk("stall_lat", lat, 32'd8);
    chk("stall_err", {31'b0, err}, 32'd0);
    chk("stall_re_cnt", re_cnt, 32'd4);
    chk("stall_we_cnt", we_cnt, 32'd3);
    chk("stall_stable", {31'b0, unstable}, 32'd0);
    chk("stall_word", mem_word, 32'h1122_AA44);
    @(posedge clk); #1;
    chk("idle_after_done", {31'b0, busy}, 32'd0);
    run(3'b010, 32'h0000_0100, 32'h0BAD_F00D, 1'b0, lat);
    chk("b2b_lat", lat, 32'd2);
    chk("b2b_word", mem_word, 32'h0BAD_F00D);
    chk("never_re_we", {31'b0, both_hi}, 32'd0);

    preload(32'h1122_3344, 0, 0);
    run(3'b000, 32'hFFFF_FFFF, 32'h0000_00AA, 1'b0, lat);
    chk("wrap_addr", last_addr, 32'hFFFF_FFFC);
    chk("wrap_word", mem_word, 32'hAA22_3344);

    preload(32'h0, 0, 5);
    @(negedge clk);
    start = 1'b1; stype = 3'b010; addr = 32'h0000_0100; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_we", {31'b0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'b0, mem_we}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    preload(32'h0, 0, 0);
    run(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 1'b0, lat);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_err", {31'b0, err}, 32'd0);
    chk("post_rst_addr", last_addr, 32'h0000_0104);
    chk("post_rst_word", mem_word, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/storemerge_rv32i.md
Name: storemerge_rv32i

Overview:
- Store-path counterpart of the load selector: executes SB, SH and SW into a word-only data memory that has no byte enables.
- SW is a single aligned word write.
- SB and SH are done as read-modify-write: read the word, replace the byte or halfword lane, write the word back.
- Sits between the core's store issue and the data memory port, with a start/done handshake toward the core and a re/we/ready handshake toward memory.

Parameters:
- ADDR_WIDTH, 32, width of the byte address and of mem_addr.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  store request; sampled only in IDLE.
- type  input  3  store type, RV32I funct3 encoding: 000 SB, 001 SH, 010 SW; others invalid.
- addr  input  ADDR_WIDTH  byte address of the store.
- wdata  input  32  store data from rs2; SB uses [7:0], SH uses [15:0].
- mem_addr  output  ADDR_WIDTH  word-aligned address, {addr_q[ADDR_WIDTH-1:2], 2'b00}.
- mem_re  output  1  memory read request.
- mem_we  output  1  memory write request.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  read data; valid in a cycle where mem_re and mem_ready are both 1.
- mem_ready  input  1  memory accepts or completes the current re/we this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 means misaligned or invalid type, and no memory access was made.

Behaviour:
- **Reset:** rst_n low forces, asynchronously, state=IDLE and mem_re=mem_we=done=err=busy=0. Latched registers and mem_addr/mem_wdata go to 0.
- **Reset mid-operation:** the store is aborted. If reset hits during WRITE, whether the memory word was updated is undefined.
- **Accepting a request:** in IDLE with start=1, latch type, addr and wdata into type_q, addr_q and wdata_q, then branch:
  - invalid type, SH with addr[0]=1, or SW with addr[1:0]!=0 → ERR;
  - SW aligned → WRITE;
  - SB or SH aligned → READ.
- **Ignored inputs:** start outside IDLE is ignored. Inputs after latching are don't-care.
- **READ:** mem_re=1. On mem_ready=1, capture the merged word into wdata_q and go to WRITE. Otherwise hold.
- **Merge rule for SB:** byte lane k = addr_q[1:0] (lane 0 = bits [7:0]). merged = mem_rdata with bits [8k+7:8k] replaced by wdata_q[7:0].
- **Merge rule for SH:** lane = addr_q[1]. Lane 0 replaces bits [15:0], lane 1 replaces bits [31:16], using wdata_q[15:0].
- **WRITE:** mem_we=1 and mem_wdata=wdata_q (merged word, or the full word for SW). On mem_ready=1 go to DONE. Otherwise hold; mem_addr and mem_wdata stay stable.
- **DONE:** done=1 and err=0 for exactly one cycle, then IDLE.
- **ERR:** done=1 and err=1 for one cycle, then IDLE. mem_re and mem_we are never asserted for a rejected request.
- **Moore outputs:**
  - mem_re=1 only in READ; mem_we=1 only in WRITE; the two are never high together.
  - busy=1 in READ, WRITE, DONE and ERR. A new start is therefore accepted no earlier than the cycle after done.
- **Latency with mem_ready held at 1** (start sampled at edge T):
  - SW: WRITE in cycle T+1, done in cycle T+2.
  - SB/SH: READ T+1, WRITE T+2, done T+3.
  - ERR: done in cycle T+1.
  - Each cycle mem_ready is low adds one cycle.
- **No timeout:** READ or WRITE waits indefinitely on mem_ready.
- **Wrap-around:** addr near 0xFFFFFFFC has no special handling; mem_addr simply truncates the low 2 bits.

Test Plan:
- SW aligned: memory word 0x11223344 at 0x100, start type=010 addr=0x100 wdata=0xDEADBEEF, mem_ready=1 → one mem_we cycle with mem_wdata=0xDEADBEEF, no mem_re, done at T+2, err=0, word becomes 0xDEADBEEF.
- SB all lanes: word 0x11223344, SB wdata=0xFFFFFFAA to addr 0x100, 0x101, 0x102, 0x103 separately → resulting words:
  - 0x112233AA
  - 0x1122AA44
  - 0x11AA3344
  - 0xAA223344
  - mem_addr=0x100 in every case, done at T+3.
- SH lanes: word 0x11223344, SH wdata=0x0000BEEF to 0x100 → 0x1122BEEF; to 0x102 → 0xBEEF3344.
- Misalignment/invalid: SH addr=0x101, SW addr=0x102, type=011 → err=1 with done at T+1; mem_re and mem_we stay 0; memory unchanged.
- Stalls and handshake:
  - SB to 0x101 with mem_ready low for 3 cycles in READ and 2 in WRITE → done at T+8.
  - mem_addr and mem_wdata stable while stalled.
  - start pulses while busy are ignored; a back-to-back start on the cycle after done is accepted.
- Async reset: assert rst_n=0 mid-WRITE between clock edges → mem_we, busy and done fall immediately. After release, the block is IDLE and a fresh SW completes normally.
